// File: rtl/result_stream_sequencer_if.sv
`default_nettype none
// ============================================================================
// result_stream_sequencer_if : result-RAM read ports and CPU beat handshake
// Revision: 1.0
// ============================================================================
interface result_stream_sequencer_if #(
  parameter int ADDRESS_WIDTH = 13,
  parameter int DATA_WIDTH    = 64
);
  logic                     Sending_Enable;
  logic [ADDRESS_WIDTH-1:0] RAM_Address_A;
  logic [DATA_WIDTH-1:0]    RAM_Data_A;
  logic [ADDRESS_WIDTH-1:0] RAM_Address_B;
  logic [DATA_WIDTH-1:0]    RAM_Data_B;
  logic [31:0]              CPU_Bus;
  logic                     CPU_Valid;
  logic                     CPU_Ready;
  logic                     Busy;
  logic                     Done_Sending;

  modport master (
    input  Sending_Enable,
    output RAM_Address_A,
    input  RAM_Data_A,
    output RAM_Address_B,
    input  RAM_Data_B,
    output CPU_Bus,
    output CPU_Valid,
    input  CPU_Ready,
    output Busy,
    output Done_Sending
  );

  modport slave (
    output Sending_Enable,
    input  RAM_Address_A,
    output RAM_Data_A,
    input  RAM_Address_B,
    output RAM_Data_B,
    input  CPU_Bus,
    input  CPU_Valid,
    output CPU_Ready,
    input  Busy,
    input  Done_Sending
  );
endinterface
`default_nettype wire

// File: rtl/result_stream_sequencer.sv
`default_nettype none
// ============================================================================
// result_stream_sequencer : streams solver results from result RAM to the CPU
//   bus as 32-bit valid/ready beats. Optional macro RESULTS_HEADER_EN adds a
//   leading {T_num, N} beat.
// Revision: 1.0
// ============================================================================
module result_stream_sequencer #(
  parameter int ADDRESS_WIDTH = 13,
  parameter int DATA_WIDTH    = 64,
  parameter int COUNT_ADDRESS = 1,
  parameter int N_ADDRESS     = 2,
  parameter int T_ADDRESS     = 3,
  parameter int X_ADDRESS     = 10
) (
  input  wire logic                  CLK,
  input  wire logic                  RST,
  result_stream_sequencer_if.master  bus
);

  localparam logic [ADDRESS_WIDTH-1:0] c_COUNT_ADDR = ADDRESS_WIDTH'(COUNT_ADDRESS);
  localparam logic [ADDRESS_WIDTH-1:0] c_N_ADDR     = ADDRESS_WIDTH'(N_ADDRESS);
  localparam logic [ADDRESS_WIDTH-1:0] c_T_BASE     = ADDRESS_WIDTH'(T_ADDRESS);
  localparam logic [ADDRESS_WIDTH-1:0] c_X_BASE     = ADDRESS_WIDTH'(X_ADDRESS);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_HDR_REQ  = 4'd1,
    S_HDR_LAT  = 4'd2,
    S_FETCH    = 4'd3,
    S_LOAD     = 4'd4,
    S_SEND_HI  = 4'd5,
    S_SEND_LO  = 4'd6,
    S_DONE     = 4'd7,
    S_HDR_SEND = 4'd8
  } state_t;

  state_t                   r_state;
  logic                     r_se_d;
  logic [15:0]              r_t_num;
  logic [15:0]              r_n_num;
  logic [15:0]              r_t_idx;
  logic [15:0]              r_x_idx;
  logic                     r_in_x;
  logic [ADDRESS_WIDTH-1:0] r_x_base;
  logic [31:0]              r_word_lo;
  logic [ADDRESS_WIDTH-1:0] r_addr_a;
  logic [ADDRESS_WIDTH-1:0] r_addr_b;
  logic [31:0]              r_cpu_bus;
  logic                     r_cpu_valid;
  logic                     r_busy;
  logic                     r_done;

  logic                     w_start;
  logic                     w_beat;
  logic                     w_word_end;
  logic [31:0]              w_first_beat;
  logic                     w_last_word;
  logic                     w_next_in_x;
  logic [15:0]              w_next_t_idx;
  logic [15:0]              w_next_x_idx;
  logic [ADDRESS_WIDTH-1:0] w_next_x_base;
  logic [ADDRESS_WIDTH-1:0] w_next_addr;
  logic                     w_unused_b;

  assign w_start    = bus.Sending_Enable & ~r_se_d;
  assign w_beat     = r_cpu_valid & bus.CPU_Ready;
  assign w_word_end = w_beat & ((r_state == S_SEND_LO) |
                                ((r_state == S_SEND_HI) & (DATA_WIDTH != 64)));
  assign w_unused_b = ^bus.RAM_Data_B[DATA_WIDTH-1:16];

  generate
    if (DATA_WIDTH == 64) begin : g_dw64
      assign w_first_beat = bus.RAM_Data_A[DATA_WIDTH-1:32];
    end else begin : g_dw32
      assign w_first_beat = bus.RAM_Data_A[31:0];
    end
  endgenerate

  // Successor of the word just sent: T[t] -> X[t][0..N-1] -> T[t+1]
  always_comb begin
    w_next_in_x   = 1'b0;
    w_next_t_idx  = r_t_idx;
    w_next_x_idx  = '0;
    w_next_x_base = r_x_base;
    w_next_addr   = '0;
    w_last_word   = 1'b0;
    if (!r_in_x && (r_n_num != 16'd0)) begin
      w_next_in_x = 1'b1;
      w_next_addr = c_X_BASE + r_x_base;
    end else if (r_in_x && ((r_x_idx + 16'd1) != r_n_num)) begin
      w_next_in_x  = 1'b1;
      w_next_x_idx = r_x_idx + 16'd1;
      w_next_addr  = c_X_BASE + r_x_base + ADDRESS_WIDTH'(r_x_idx + 16'd1);
    end else begin
      w_last_word   = ((r_t_idx + 16'd1) == r_t_num);
      w_next_t_idx  = r_t_idx + 16'd1;
      w_next_x_base = r_x_base + ADDRESS_WIDTH'(r_n_num);
      w_next_addr   = c_T_BASE + ADDRESS_WIDTH'(r_t_idx + 16'd1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_se_d      <= 1'b1;  // a level already high at reset release is not an edge
      r_t_num     <= '0;
      r_n_num     <= '0;
      r_t_idx     <= '0;
      r_x_idx     <= '0;
      r_in_x      <= 1'b0;
      r_x_base    <= '0;
      r_word_lo   <= '0;
      r_addr_a    <= '0;
      r_addr_b    <= '0;
      r_cpu_bus   <= '0;
      r_cpu_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_se_d <= bus.Sending_Enable;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state  <= S_HDR_REQ;
            r_busy   <= 1'b1;
            r_addr_a <= c_COUNT_ADDR;
            r_addr_b <= c_N_ADDR;
          end
        end
        S_HDR_REQ: begin
          r_state  <= S_HDR_LAT;
          r_addr_b <= '0;
        end
        S_HDR_LAT: begin
          r_t_num  <= bus.RAM_Data_A[15:0];
          r_n_num  <= bus.RAM_Data_B[15:0];
          r_t_idx  <= '0;
          r_x_idx  <= '0;
          r_in_x   <= 1'b0;
          r_x_base <= '0;
          r_addr_a <= c_T_BASE;
`ifdef RESULTS_HEADER_EN
          r_state     <= S_HDR_SEND;
          r_cpu_valid <= 1'b1;
          r_cpu_bus   <= {bus.RAM_Data_A[15:0], bus.RAM_Data_B[15:0]};
`else
          if (bus.RAM_Data_A[15:0] == 16'd0) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_FETCH;
          end
`endif
        end
`ifdef RESULTS_HEADER_EN
        S_HDR_SEND: begin
          if (w_beat) begin
            r_cpu_valid <= 1'b0;
            r_cpu_bus   <= '0;
            if (r_t_num == 16'd0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_FETCH;
            end
          end
        end
`endif
        S_FETCH: r_state <= S_LOAD;
        S_LOAD: begin
          r_word_lo   <= bus.RAM_Data_A[31:0];
          r_cpu_bus   <= w_first_beat;
          r_cpu_valid <= 1'b1;
          r_state     <= S_SEND_HI;
        end
        S_SEND_HI: begin
          if (w_beat && (DATA_WIDTH == 64)) begin
            r_state   <= S_SEND_LO;
            r_cpu_bus <= r_word_lo;
          end
        end
        S_SEND_LO: ;
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_word_end) begin
        r_cpu_valid <= 1'b0;
        r_cpu_bus   <= '0;
        r_in_x      <= w_next_in_x;
        r_x_idx     <= w_next_x_idx;
        r_t_idx     <= w_next_t_idx;
        r_x_base    <= w_next_x_base;
        if (w_last_word) begin
          r_state  <= S_DONE;
          r_done   <= 1'b1;
          r_addr_a <= '0;
        end else begin
          r_state  <= S_FETCH;
          r_addr_a <= w_next_addr;
        end
      end
    end
  end

  assign bus.RAM_Address_A = r_addr_a;
  assign bus.RAM_Address_B = r_addr_b;
  assign bus.CPU_Bus       = r_cpu_bus;
  assign bus.CPU_Valid     = r_cpu_valid;
  assign bus.Busy          = r_busy;
  assign bus.Done_Sending  = r_done;

endmodule
`default_nettype wire

// File: doc/result_stream_sequencer.md
Name: result_stream_sequencer

Overview:
- Controller that streams solver results from dual-port result RAM to the 32-bit CPU bus.
- On start, reads the header words (time-step count T_num and state-vector size N), then walks the result layout in fixed order.
- Splits each DATA_WIDTH word into 32-bit beats and paces every beat with a valid/ready handshake.
- Sits between the result RAM read ports and the IO module's CPU interface.

Parameters:
ADDRESS_WIDTH  13  RAM address width
DATA_WIDTH  64  RAM word width; legal values 32 or 64
COUNT_ADDRESS  1  address of T_num header word (port A)
N_ADDRESS  2  address of N header word (port B)
T_ADDRESS  3  base address of time values T[t]
X_ADDRESS  10  base address of state values X[t][i]

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous, active-high reset
Sending_Enable  in  1  start request; the rising edge starts a transfer
RAM_Address_A  out  ADDRESS_WIDTH  port A read address, registered
RAM_Data_A  in  DATA_WIDTH  port A read data, valid one cycle after address
RAM_Address_B  out  ADDRESS_WIDTH  port B read address, registered
RAM_Data_B  in  DATA_WIDTH  port B read data, valid one cycle after address
CPU_Bus  out  32  beat data
CPU_Valid  out  1  beat valid
CPU_Ready  in  1  CPU accepts beat
Busy  out  1  high from start until the Done pulse, inclusive
Done_Sending  out  1  one-cycle pulse after the last beat

Behaviour:
- Reset: every output is 0 and the state is IDLE. RST mid-transfer aborts at once with no Done pulse; the next start needs a fresh rising edge of Sending_Enable.
- Start: rising edge of Sending_Enable (registered edge detect) sampled in IDLE. Edges seen while Busy are ignored. A level held high does not restart the block.
- States: IDLE, HDR_REQ, HDR_LAT, FETCH, LOAD, SEND_HI, SEND_LO, DONE.
- IDLE -> HDR_REQ on start. HDR_REQ drives A=COUNT_ADDRESS and B=N_ADDRESS.
- HDR_REQ -> HDR_LAT. At the end of HDR_LAT, latch T_num=RAM_Data_A[15:0] and N=RAM_Data_B[15:0], then go to FETCH, or to DONE if T_num==0.
- Read order: for t = 0..T_num-1, first T[t] at T_ADDRESS+t, then X[t][i] at X_ADDRESS+t*N+i for i = 0..N-1.
- The t*N offset is a running accumulator (add N per step), not a multiplier. All address arithmetic is modulo 2^ADDRESS_WIDTH and wraps silently.
- FETCH drives the port A address. LOAD captures RAM_Data_A into the word register.
- SEND_HI presents the word's [63:32] when DATA_WIDTH==64, or [31:0] when DATA_WIDTH==32 (in which case SEND_LO is skipped). SEND_LO presents [31:0].
- In SEND states, CPU_Valid=1. CPU_Bus holds stable until the cycle where Valid&Ready==1; the beat transfers on that edge.
- After the final beat of a word: advance i/t and go to FETCH, or to DONE after the last word.
- Timing: a start sampled at edge k gives CPU_Valid=1 from edge k+4. There are 2 bubble cycles between words.
- DONE: Done_Sending=1 and Busy=1 for one cycle, then IDLE with Busy=0.
- N==0: only T values are sent.
- Port B is used only for the header; RAM_Address_B returns to 0 afterwards.
- CPU_Ready high outside SEND states is ignored.

Optional Feature:
Macro RESULTS_HEADER_EN.
- Defined: after the header is latched, one extra beat {T_num[15:0], N[15:0]} is sent under the same handshake before T[0]. This beat is sent even when T_num==0, and then the block goes to DONE.
- Undefined: no header beat; behaviour exactly as above.

Test Plan:
- Reset then start, DATA_WIDTH=64, T_num=2, N=1, CPU_Ready=1 -> 8 beats in order: T[0] hi/lo (addr 3), X[0][0] (addr 10), T[1] (addr 4), X[1][0] (addr 11). First Valid at edge k+4. Done pulses once after beat 8.
- Same setup with CPU_Ready toggling 1-0-0-1 -> CPU_Bus stable while Valid&!Ready, no beat lost or duplicated, same 8-beat sequence.
- T_num=0 -> no CPU_Valid, Done_Sending one cycle after HDR_LAT. With RESULTS_HEADER_EN: exactly one beat 0x0000_000N, then Done.
- T_num=3, N=2, DATA_WIDTH=32 -> 9 beats from addresses 3, 10, 11, 4, 12, 13, 5, 14, 15.
- Assert RST during the 3rd beat -> all outputs 0 immediately, no Done. A new rising edge of Sending_Enable restarts from the header.
- Hold Sending_Enable high through Done -> no second transfer. Low for 1 cycle then high -> new transfer.
